bip_ctrl_seq: RTL and testbench

BIP_CTRL_SEQ -- requirements
Module: bip_ctrl_seq

---
 rtl/bip_ctrl_seq.sv | 176 +++++++++++++++++
 tb/tb_bip_ctrl_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_ctrl_seq.sv
// bip_ctrl_seq -- control sequencer for a small accumulator CPU.
//
// Each instruction runs FETCH -> DECODE -> EXEC (three cycles). HLT parks
// the sequencer in HALT until reset.
//
// Handshake: the program memory is synchronous. imem_rd/pc_addr are
// presented in FETCH and the read data on instr is valid in the following
// cycle (DECODE), where it is latched into the instruction register.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable         run permission, only looked at in FETCH
//   acc_zero       accumulator == 0 flag, sampled in EXEC for BEQ/BNE
//   instr          program-memory read data, opcode in the MSBs
//   pc_addr        program-memory address (current PC)
//   imem_rd        program-memory read strobe (FETCH only)
//   operand        operand field of the latched instruction
//   sel_a, sel_b   accumulator / ALU-B source selects
//   op             ALU operation (0 SUB, 1 ADD, 2 AND, 3 XOR)
//   wr_acc, wr_ram, rd_ram   datapath strobes, one EXEC cycle wide
//   halted         high once HLT has executed
//   retired        saturating count of executed instructions
//   dbg_state      current FSM state (0 FETCH, 1 DECODE, 2 EXEC, 3 HALT)
module bip_ctrl_seq #(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5,
    parameter int OPD_W = 11,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   acc_zero,
    input  logic [OPC_W+OPD_W-1:0] instr,
    output logic [PC_W-1:0]        pc_addr,
    output logic                   imem_rd,
    output logic [OPD_W-1:0]       operand,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic [1:0]             op,
    output logic                   wr_acc,
    output logic                   wr_ram,
    output logic                   rd_ram,
    output logic                   halted,
    output logic [CNT_W-1:0]       retired,
    output logic [1:0]             dbg_state
);

    localparam int IR_W = OPC_W + OPD_W;

    localparam logic [OPC_W-1:0] OPC_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OPC_ANDI = OPC_W'(9);
    localparam logic [OPC_W-1:0] OPC_XOR  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OPC_XORI = OPC_W'(11);
    localparam logic [OPC_W-1:0] OPC_JMP  = OPC_W'(12);
    localparam logic [OPC_W-1:0] OPC_BEQ  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OPC_BNE  = OPC_W'(14);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [OPC_W-1:0]  opcode;
    logic              take_branch;

    assign opcode = ir_q[IR_W-1 -: OPC_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, PC and IR update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        take_branch = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (enable) state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                take_branch = (opcode == OPC_JMP) ||
                              ((opcode == OPC_BEQ) &&  acc_zero) ||
                              ((opcode == OPC_BNE) && !acc_zero);
                // Sequential PC wraps naturally at PC_W bits.
                pc_d = take_branch ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
                if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
                state_d = (opcode == OPC_HLT) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath strobes: only EXEC decodes the IR; every other state is quiet.
    always_comb begin
        wr_acc = 1'b0;
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        sel_a  = 2'd0;
        sel_b  = 1'b0;
        op     = 2'd0;
        if (state_q == S_EXEC) begin
            case (opcode)
                OPC_STO: wr_ram = 1'b1;
                OPC_LD: begin
                    wr_acc = 1'b1;
                    rd_ram = 1'b1;
                end
                OPC_LDI: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'd1;
                end
                OPC_ADD, OPC_SUB, OPC_AND, OPC_XOR: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'd2;
                    rd_ram = 1'b1;
                end
                OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_XORI: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'd2;
                    sel_b  = 1'b1;
                end
                default: ;
            endcase
            case (opcode)
                OPC_ADD, OPC_ADDI: op = 2'd1;
                OPC_AND, OPC_ANDI: op = 2'd2;
                OPC_XOR, OPC_XORI: op = 2'd3;
                default:           op = 2'd0;
            endcase
        end
    end

    assign pc_addr   = pc_q;
    assign imem_rd   = (state_q == S_FETCH);
    assign operand   = ir_q[OPD_W-1:0];
    assign halted    = (state_q == S_HALT);
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bip_ctrl_seq.sv
module tb_bip_ctrl_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        acc_zero = 1'b0;
  logic [15:0] instr;
  logic [10:0] pc_addr;
  logic        imem_rd;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic [1:0]  op;
  logic        wr_acc, wr_ram, rd_ram, halted;
  logic [15:0] retired;
  logic [1:0]  dbg_state;

  bip_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .acc_zero(acc_zero),
    .instr(instr), .pc_addr(pc_addr), .imem_rd(imem_rd), .operand(operand),
    .sel_a(sel_a), .sel_b(sel_b), .op(op), .wr_acc(wr_acc), .wr_ram(wr_ram),
    .rd_ram(rd_ram), .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  // second instance with a narrow retired counter, fed a constant NOP
  logic        rst2_n = 1'b0;
  logic        en2 = 1'b0;
  logic [15:0] nop_instr = {5'd15, 11'd0};
  logic [10:0] pc_addr2;
  logic        imem_rd2;
  logic [10:0] operand2;
  logic [1:0]  sel_a2;
  logic        sel_b2;
  logic [1:0]  op2;
  logic        wr_acc2, wr_ram2, rd_ram2, halted2;
  logic [3:0]  retired2;
  logic [1:0]  dbg_state2;

  bip_ctrl_seq #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(en2), .acc_zero(1'b0),
    .instr(nop_instr), .pc_addr(pc_addr2), .imem_rd(imem_rd2), .operand(operand2),
    .sel_a(sel_a2), .sel_b(sel_b2), .op(op2), .wr_acc(wr_acc2), .wr_ram(wr_ram2),
    .rd_ram(rd_ram2), .halted(halted2), .retired(retired2), .dbg_state(dbg_state2)
  );

  // synchronous program memory model
  logic [15:0] mem [0:2047];
  always @(posedge clk) if (imem_rd) instr <= mem[pc_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [18:0] exp_q[$];

  // expected EXEC-cycle word {wr_acc, sel_a, sel_b, op, rd_ram, wr_ram, operand}
  function automatic logic [18:0] ref_word(input logic [4:0] opc, input logic [10:0] opd);
    logic wa, sb, rr, wr;
    logic [1:0] sa, o;
    wa = 0; sb = 0; rr = 0; wr = 0; sa = 0; o = 0;
    case (opc)
      5'd1: wr = 1;
      5'd2: begin wa = 1; rr = 1; end
      5'd3: begin wa = 1; sa = 1; end
      5'd4, 5'd6, 5'd8, 5'd10: begin wa = 1; sa = 2; rr = 1; end
      5'd5, 5'd7, 5'd9, 5'd11: begin wa = 1; sa = 2; sb = 1; end
      default: ;
    endcase
    case (opc)
      5'd4, 5'd5:   o = 2'd1;
      5'd8, 5'd9:   o = 2'd2;
      5'd10, 5'd11: o = 2'd3;
      default:      o = 2'd0;
    endcase
    return {wa, sa, sb, o, rr, wr, opd};
  endfunction

  always @(negedge clk) begin
    logic [18:0] obs, exp_w;
    if (rst_n === 1'b1) begin
      obs = {wr_acc, sel_a, sel_b, op, rd_ram, wr_ram, operand};
      n_cmp++;
      if (dbg_state === 2'd2) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL exec_unexpected: got %h, no instruction expected", obs);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin
            n_fail++;
            $display("FAIL exec_strobes: got %h, expected %h", obs, exp_w);
          end
        end
      end else if (obs[18:11] !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_strobes: got %h in state %0d, expected 00", obs[18:11], dbg_state);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = {5'd15, 11'd0};
  endtask

  task automatic do_reset(input logic en);
    rst_n = 1'b0;
    enable = en;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d instructions never executed, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mem();
    do_reset(1'b0);
    n_cmp++;
    if ({pc_addr, imem_rd, halted, retired, operand} !== {11'd0, 1'b1, 1'b0, 16'd0, 11'd0}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%0d rd=%b halt=%b ret=%0d opd=%0d, expected 0 1 0 0 0",
               pc_addr, imem_rd, halted, retired, operand);
    end
  endtask

  task automatic test_program();
    logic [12:1] seen;
    clear_mem();
    mem[0] = {5'd3, 11'd5};
    mem[1] = {5'd5, 11'd3};
    mem[2] = {5'd1, 11'd7};
    mem[3] = {5'd0, 11'd0};
    exp_q.push_back(ref_word(5'd3, 11'd5));
    exp_q.push_back(ref_word(5'd5, 11'd3));
    exp_q.push_back(ref_word(5'd1, 11'd7));
    exp_q.push_back(ref_word(5'd0, 11'd0));
    do_reset(1'b1);
    for (int i = 1; i <= 12; i++) begin
      step();
      seen[i] = wr_acc | wr_ram | rd_ram;
      if (i == 8) begin
        n_cmp++;
        if ({wr_ram, operand} !== {1'b1, 11'd7}) begin
          n_fail++;
          $display("FAIL sto_strobe: wr_ram=%b operand=%0d, expected 1 7", wr_ram, operand);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if (halted !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_early: halted=%b after 11 cycles, expected 0", halted);
        end
      end
    end
    n_cmp++;
    if (seen !== 12'b0000_1001_0010) begin
      n_fail++;
      $display("FAIL strobe_spacing: pattern %b, expected 000010010010", seen);
    end
    n_cmp++;
    if ({halted, retired} !== {1'b1, 16'd4}) begin
      n_fail++;
      $display("FAIL halt_state: halted=%b retired=%0d, expected 1 4", halted, retired);
    end
    for (int i = 0; i < 5; i++) begin
      enable = i[0];
      step();
      n_cmp++;
      if ({halted, imem_rd, pc_addr, retired} !== {1'b1, 1'b0, 11'd4, 16'd4}) begin
        n_fail++;
        $display("FAIL halt_hold: halted=%b rd=%b pc=%0d ret=%0d, expected 1 0 4 4",
                 halted, imem_rd, pc_addr, retired);
      end
    end
    check_drained("program");
  endtask

  task automatic test_branch();
    logic [4:0]  opc_t[5] = '{5'd13, 5'd13, 5'd14, 5'd14, 5'd12};
    logic        az_t[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [10:0] pc_t[5]  = '{11'd20, 11'd1, 11'd20, 11'd1, 11'd20};
    for (int k = 0; k < 5; k++) begin
      clear_mem();
      mem[0] = {opc_t[k], 11'd20};
      acc_zero = az_t[k];
      exp_q.push_back(ref_word(opc_t[k], 11'd20));
      do_reset(1'b1);
      step(); step(); step();
      enable = 1'b0;
      n_cmp++;
      if (pc_addr !== pc_t[k]) begin
        n_fail++;
        $display("FAIL branch_%0d: pc=%0d, expected %0d", k, pc_addr, pc_t[k]);
      end
    end
    acc_zero = 1'b0;
    check_drained("branch");
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = {5'd3, 11'd9};
    exp_q.push_back(ref_word(5'd3, 11'd9));
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({pc_addr, imem_rd, retired} !== {11'd0, 1'b1, 16'd0}) begin
        n_fail++;
        $display("FAIL stall_%0d: pc=%0d rd=%b ret=%0d, expected 0 1 0", i, pc_addr, imem_rd, retired);
      end
    end
    enable = 1'b1;
    step();
    n_cmp++;
    if (imem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resume: imem_rd=%b one cycle after enable, expected 0", imem_rd);
    end
    step();
    enable = 1'b0;
    step();
    n_cmp++;
    if ({pc_addr, retired} !== {11'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL stall_after: pc=%0d ret=%0d, expected 1 1", pc_addr, retired);
    end
    check_drained("stall");
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = {5'd12, 11'd2047};
    exp_q.push_back(ref_word(5'd12, 11'd2047));
    exp_q.push_back(ref_word(5'd15, 11'd0));
    do_reset(1'b1);
    step(); step(); step();
    n_cmp++;
    if (pc_addr !== 11'd2047) begin
      n_fail++;
      $display("FAIL wrap_jmp: pc=%0d, expected 2047", pc_addr);
    end
    step(); step();
    enable = 1'b0;
    step();
    n_cmp++;
    if ({pc_addr, retired} !== {11'd0, 16'd2}) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%0d ret=%0d, expected 0 2", pc_addr, retired);
    end
    check_drained("wrap");
  endtask

  task automatic test_saturate();
    rst2_n = 1'b0;
    en2 = 1'b1;
    step(); step();
    rst2_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(); step(); step();
      if (n == 14 || n == 15 || n == 20) begin
        n_cmp++;
        if (retired2 !== ((n > 15) ? 4'd15 : 4'(n))) begin
          n_fail++;
          $display("FAIL sat_%0d: retired=%0d, expected %0d", n, retired2, (n > 15) ? 15 : n);
        end
      end
    end
    n_cmp++;
    if (pc_addr2 !== 11'd20) begin
      n_fail++;
      $display("FAIL sat_pc: pc=%0d, expected 20", pc_addr2);
    end
    en2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic saw_wr;
    clear_mem();
    mem[0] = {5'd1, 11'd7};
    do_reset(1'b1);
    step();                 // now in DECODE of STO
    saw_wr = wr_ram;
    rst_n = 1'b0;
    enable = 1'b0;
    step();
    saw_wr |= wr_ram;
    rst_n = 1'b1;
    n_cmp++;
    if ({pc_addr, imem_rd, operand, retired} !== {11'd0, 1'b1, 11'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL midreset_state: pc=%0d rd=%b opd=%0d ret=%0d, expected 0 1 0 0",
               pc_addr, imem_rd, operand, retired);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      saw_wr |= wr_ram;
    end
    n_cmp++;
    if (saw_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_wr: wr_ram seen=%b, expected 0", saw_wr);
    end
    check_drained("midreset");
  endtask

  task automatic test_undefined();
    clear_mem();
    mem[0] = {5'd31, 11'h055};
    exp_q.push_back(ref_word(5'd31, 11'h055));
    do_reset(1'b1);
    step(); step();
    enable = 1'b0;
    step();
    n_cmp++;
    if ({pc_addr, operand} !== {11'd1, 11'h055}) begin
      n_fail++;
      $display("FAIL undef: pc=%0d opd=%h, expected 1 055", pc_addr, operand);
    end
    check_drained("undef");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  opc;
    logic [10:0] opd;
    int r;
    clear_mem();
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(1, 13);
      opc = (r <= 11) ? 5'(r) : ((r == 12) ? 5'd15 : 5'd31);
      opd = 11'($urandom_range(0, 2047));
      mem[i] = {opc, opd};
      exp_q.push_back(ref_word(opc, opd));
    end
    do_reset(1'b1);
    for (int i = 0; i < 24; i++) step();
    enable = 1'b0;
    n_cmp++;
    if ({pc_addr, retired} !== {11'd8, 16'd8}) begin
      n_fail++;
      $display("FAIL b2b_end: pc=%0d ret=%0d, expected 8 8", pc_addr, retired);
    end
    check_drained("b2b");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_program();
    test_branch();
    test_stall();
    test_pc_wrap();
    test_saturate();
    test_reset_mid();
    test_undefined();
    test_back_to_back();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
